// File: rtl/gem_trig_link_pkg.sv
// Shared constants for the GEM trigger-link framer: K-codes, idle word, lane geometry.
// Used by gem_trig_link_framer and gem_trig_link_lane.
package gem_trig_link_pkg;

    localparam logic [7:0] K_BC     = 8'hBC;
    localparam logic [7:0] K_F7     = 8'hF7;
    localparam logic [7:0] K_FB     = 8'hFB;
    localparam logic [7:0] K_FD     = 8'hFD;
    localparam logic [7:0] K_BC0    = 8'h1C;
    localparam logic [7:0] K_RESYNC = 8'h3C;
    localparam logic [7:0] K_OVF    = 8'hFC;

    localparam logic [15:0] IDLE_WORD = 16'hFFBC;
    localparam logic [1:0]  IDLE_ISK  = 2'b01;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned LANE_W  = 56;

    typedef enum logic [1:0] {
        FRM_SEP = 2'd0,
        FRM_W1  = 2'd1,
        FRM_W2  = 2'd2,
        FRM_W3  = 2'd3
    } frame_e;

    // BX-sequence K-code rotation BC, F7, FB, FD
    function automatic logic [7:0] seq_code(input logic [1:0] sel);
        logic [7:0] code;
        case (sel)
            2'd0:    code = K_BC;
            2'd1:    code = K_F7;
            2'd2:    code = K_FB;
            2'd3:    code = K_FD;
            default: code = K_BC;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gem_trig_link_lane.sv
// One trigger-link lane: picks the 16-bit slice of its 56-bit payload for the
// current frame word and registers tx_data/tx_isk.
module gem_trig_link_lane
    import gem_trig_link_pkg::*;
(
    input  logic              usrclk_160,
    input  logic              i_idle,
    input  frame_e            i_frame,
    input  logic [LANE_W-1:0] i_data,
    input  logic [7:0]        i_sep,
    output logic [15:0]       o_tx_data,
    output logic [1:0]        o_tx_isk
);

    logic [15:0] r_tx_data;
    logic [1:0]  r_tx_isk;

    // Output word register; idle overrides the frame schedule
    always_ff @(posedge usrclk_160) begin
        if (i_idle) begin
            r_tx_data <= IDLE_WORD;
            r_tx_isk  <= IDLE_ISK;
        end else begin
            case (i_frame)
                FRM_SEP: begin
                    r_tx_data <= {i_data[7:0], i_sep};
                    r_tx_isk  <= 2'b01;
                end
                FRM_W1: begin
                    r_tx_data <= i_data[23:8];
                    r_tx_isk  <= 2'b00;
                end
                FRM_W2: begin
                    r_tx_data <= i_data[39:24];
                    r_tx_isk  <= 2'b00;
                end
                FRM_W3: begin
                    r_tx_data <= i_data[55:40];
                    r_tx_isk  <= 2'b00;
                end
                default: begin
                    r_tx_data <= IDLE_WORD;
                    r_tx_isk  <= IDLE_ISK;
                end
            endcase
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_isk  = r_tx_isk;

endmodule

// File: rtl/gem_trig_link_framer.sv
// GEM OptoHybrid trigger-link framer: four-word BX frames over four 8b/10b lanes.
// Optional macro FRAME_CTRL_TTC_EN: separator sequence code follows bxn_lsbs.
module gem_trig_link_framer
    import gem_trig_link_pkg::*;
(
    input  logic         usrclk_160,
    input  logic         reset,
    input  logic         ready,
    input  logic [111:0] gem_data,
    input  logic         overflow,
    input  logic [1:0]   bxn_lsbs,
    input  logic         bc0,
    input  logic         resync,
    output logic [15:0]  tx_data0,
    output logic [15:0]  tx_data1,
    output logic [15:0]  tx_data2,
    output logic [15:0]  tx_data3,
    output logic [1:0]   tx_isk0,
    output logic [1:0]   tx_isk1,
    output logic [1:0]   tx_isk2,
    output logic [1:0]   tx_isk3
);

    logic [1:0]  r_tx_frame;
    logic [3:0]  r_sep_cnt;
    logic        w_idle;
    logic [1:0]  w_sel;
    logic [7:0]  w_sep;
    logic [15:0] w_tx_data [N_LANES];
    logic [1:0]  w_tx_isk  [N_LANES];

    assign w_idle = reset | ~ready;

`ifdef FRAME_CTRL_TTC_EN
    assign w_sel = bxn_lsbs;
`else
    // Local rotation advances once per frame; the TTC counter is ignored
    logic w_unused_bxn;
    assign w_unused_bxn = ^bxn_lsbs;
    assign w_sel        = r_sep_cnt[3:2];
`endif

    // Frame-word and separator counters, both restart from zero after idle
    always_ff @(posedge usrclk_160) begin
        if (w_idle) begin
            r_tx_frame <= 2'd0;
            r_sep_cnt  <= 4'd0;
        end else begin
            r_tx_frame <= r_tx_frame + 2'd1;
            r_sep_cnt  <= r_sep_cnt + 4'd1;
        end
    end

    // Separator priority: BC0, then resync, then overflow, then sequence code
    always_comb begin
        w_sep = seq_code(w_sel);
        if (bc0) begin
            w_sep = K_BC0;
        end else if (resync) begin
            w_sep = K_RESYNC;
        end else if (overflow) begin
            w_sep = K_OVF;
        end else begin
            w_sep = seq_code(w_sel);
        end
    end

    // Lanes 2/3 carry duplicates of lanes 0/1
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        gem_trig_link_lane u_lane (
            .usrclk_160 (usrclk_160),
            .i_idle     (w_idle),
            .i_frame    (frame_e'(r_tx_frame)),
            .i_data     (gem_data[(l % 2) * LANE_W +: LANE_W]),
            .i_sep      (w_sep),
            .o_tx_data  (w_tx_data[l]),
            .o_tx_isk   (w_tx_isk[l])
        );
    end

    assign tx_data0 = w_tx_data[0];
    assign tx_data1 = w_tx_data[1];
    assign tx_data2 = w_tx_data[2];
    assign tx_data3 = w_tx_data[3];
    assign tx_isk0  = w_tx_isk[0];
    assign tx_isk1  = w_tx_isk[1];
    assign tx_isk2  = w_tx_isk[2];
    assign tx_isk3  = w_tx_isk[3];

endmodule

// File: tb/tb_gem_trig_link_framer.sv
// Self-checking bench for gem_trig_link_framer: directed steps followed by a
// randomized run, every output word compared against a frame-level reference model.
module tb_gem_trig_link_framer;

    logic         usrclk_160 = 1'b0;
    logic         reset      = 1'b1;
    logic         ready      = 1'b0;
    logic [111:0] gem_data   = '0;
    logic         overflow   = 1'b0;
    logic [1:0]   bxn_lsbs   = 2'd0;
    logic         bc0        = 1'b0;
    logic         resync     = 1'b0;
    logic [15:0]  tx_data0, tx_data1, tx_data2, tx_data3;
    logic [1:0]   tx_isk0, tx_isk1, tx_isk2, tx_isk3;

    int tests = 0;
    int fails = 0;
    int k     = 0;   // active cycles since the last idle cycle

    logic [15:0] dat [4];
    logic [1:0]  isk [4];
    logic [7:0]  seq_tab [4];

    always #3 usrclk_160 = ~usrclk_160;

    gem_trig_link_framer dut (
        .usrclk_160 (usrclk_160),
        .reset      (reset),
        .ready      (ready),
        .gem_data   (gem_data),
        .overflow   (overflow),
        .bxn_lsbs   (bxn_lsbs),
        .bc0        (bc0),
        .resync     (resync),
        .tx_data0   (tx_data0),
        .tx_data1   (tx_data1),
        .tx_data2   (tx_data2),
        .tx_data3   (tx_data3),
        .tx_isk0    (tx_isk0),
        .tx_isk1    (tx_isk1),
        .tx_isk2    (tx_isk2),
        .tx_isk3    (tx_isk3)
    );

    assign dat[0] = tx_data0;
    assign dat[1] = tx_data1;
    assign dat[2] = tx_data2;
    assign dat[3] = tx_data3;
    assign isk[0] = tx_isk0;
    assign isk[1] = tx_isk1;
    assign isk[2] = tx_isk2;
    assign isk[3] = tx_isk3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict all four lane words, clock, compare
    task automatic step(input logic rs, input logic rdy, input logic [111:0] gd,
                        input logic ovf, input logic [1:0] bx, input logic b0,
                        input logic rsy, input string tag);
        logic [15:0] exp_d [4];
        logic [1:0]  exp_k [4];
        logic [55:0] d;
        logic [7:0]  sep;
        logic [1:0]  sel;
        int f, n;
        reset = rs; ready = rdy; gem_data = gd; overflow = ovf;
        bxn_lsbs = bx; bc0 = b0; resync = rsy;
        f = k % 4;
        n = (k / 4) % 4;
`ifdef FRAME_CTRL_TTC_EN
        sel = bx;
`else
        sel = n[1:0];
`endif
        sep = b0 ? 8'h1C : rsy ? 8'h3C : ovf ? 8'hFC : seq_tab[sel];
        for (int l = 0; l < 4; l++) begin
            d = (l % 2 == 0) ? gd[55:0] : gd[111:56];
            if (rs || !rdy) begin
                exp_d[l] = 16'hFFBC;
                exp_k[l] = 2'b01;
            end else if (f == 0) begin
                exp_d[l] = {d[7:0], sep};
                exp_k[l] = 2'b01;
            end else begin
                exp_d[l] = 16'(d >> (16 * f - 8));
                exp_k[l] = 2'b00;
            end
        end
        if (rs || !rdy) k = 0;
        else            k = k + 1;
        @(posedge usrclk_160);
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            assert ({isk[l], dat[l]} === {exp_k[l], exp_d[l]}) else begin
                fails++;
                $error("FAIL %s lane%0d: observed %h/%b expected %h/%b",
                       tag, l, dat[l], isk[l], exp_d[l], exp_k[l]);
            end
        end
    endtask

    function automatic logic [111:0] rnd112();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [111:0] pat;
        seq_tab[0] = 8'hBC; seq_tab[1] = 8'hF7; seq_tab[2] = 8'hFB; seq_tab[3] = 8'hFD;

        // Reset held, then ready low: idle words, counters parked at zero
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "reset");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, rnd112(), 1'b1, 2'd1, 1'b1, 1'b1, "not_ready");
            chk("frame_idle", 32'(dut.r_tx_frame), 32'd0);
            chk("sepcnt_idle", 32'(dut.r_sep_cnt), 32'd0);
        end
        chk("idle_word", {14'd0, tx_isk0, tx_data0}, {14'd0, 2'b01, 16'hFFBC});

        // First frame after ready, lane split with distinct halves
        pat = {56'hFEDC_BA98_7654_32, 56'h0123_4567_89AB_CD};
        step(1'b0, 1'b1, pat, 1'b0, 2'd0, 1'b0, 1'b0, "first_f0");
        chk("lane0_f0", {14'd0, tx_isk0, tx_data0}, {14'd0, 2'b01, 16'hCDBC});
        chk("lane1_f0", {14'd0, tx_isk1, tx_data1}, {14'd0, 2'b01, 16'h32BC});
        step(1'b0, 1'b1, pat, 1'b0, 2'd0, 1'b0, 1'b0, "first_f1");
        chk("lane0_f1", {14'd0, tx_isk0, tx_data0}, {14'd0, 2'b00, 16'h89AB});
        step(1'b0, 1'b1, pat, 1'b0, 2'd0, 1'b0, 1'b0, "first_f2");
        chk("lane2_f2", {14'd0, tx_isk2, tx_data2}, {14'd0, 2'b00, 16'h4567});
        step(1'b0, 1'b1, pat, 1'b0, 2'd0, 1'b0, 1'b0, "first_f3");
        chk("lane0_f3", {14'd0, tx_isk0, tx_data0}, {14'd0, 2'b00, 16'h0123});
        chk("lane3_f3", {14'd0, tx_isk3, tx_data3}, {14'd0, 2'b00, 16'hFEDC});

        // Flag priority at frame-0 cycles
        step(1'b0, 1'b1, rnd112(), 1'b1, 2'd0, 1'b1, 1'b1, "all_flags");
        chk("sep_bc0", 32'(tx_data0[7:0]), 32'h1C);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "pad_a");
        step(1'b0, 1'b1, rnd112(), 1'b1, 2'd0, 1'b0, 1'b1, "rsy_ovf");
        chk("sep_resync", 32'(tx_data0[7:0]), 32'h3C);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "pad_b");
        step(1'b0, 1'b1, rnd112(), 1'b1, 2'd0, 1'b0, 1'b0, "ovf");
        chk("sep_ovf", 32'(tx_data0[7:0]), 32'hFC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "pad_c");

        // Five clean frames from a fresh start (bxn_lsbs = 2)
        step(1'b0, 1'b0, rnd112(), 1'b0, 2'd2, 1'b0, 1'b0, "gap");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rnd112(), 1'b0, 2'd2, 1'b0, 1'b0, "seq");

        // ready drop at tx_frame = 2 aborts the frame
        step(1'b0, 1'b0, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "gap2");
        step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "ab_f0");
        step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "ab_f1");
        step(1'b0, 1'b0, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "ab_drop");
        chk("abort_idle", {14'd0, tx_isk0, tx_data0}, {14'd0, 2'b01, 16'hFFBC});
        step(1'b0, 1'b1, rnd112(), 1'b0, 2'd0, 1'b0, 1'b0, "ab_restart");
        chk("restart_sep", {22'd0, tx_isk1, tx_data1[7:0]}, {22'd0, 2'b01, 8'hBC});

        // Randomized run with occasional idle, reset and flag activity
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0, rnd112(),
                 $urandom_range(0, 7) == 0, 2'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gem_trig_link_framer.md
# gem_trig_link_framer

Builds the 8b/10b trigger-link payload for the four GEM OptoHybrid trigger transceivers. Runs in the GTP transmit user-clock domain (160 MHz), one 40 MHz bunch crossing (BX) per four-word frame. It splits 112 bits of S-bit cluster data across four 16-bit lanes. It inserts a frame-separator K-code that encodes BX sequence, BC0, resync and cluster overflow. It sits between the cluster CDC FIFO output and the GTP wrapper's `txdata`/`txcharisk` inputs.

## Interface
- Parameters: none. All constants are fixed; see Configuration.
- `usrclk_160` in 1: transmit user clock; every register in the block is clocked by it.
- `reset` in 1: synchronous, active-high.
- `ready` in 1: AND of all four GTP `tx_fsm_reset_done` bits; already synchronous to `usrclk_160`.
- `gem_data` in 112: cluster data. [55:0] feeds lanes 0 and 2; [111:56] feeds lanes 1 and 3.
- `overflow` in 1: more than 8 clusters in this BX.
- `bxn_lsbs` in 2: BX counter bits [1:0].
- `bc0` in 1: bunch-crossing-zero flag.
- `resync` in 1: resync flag.
- `tx_data0..3` out 16: lane transmit words. Byte [7:0] is sent first.
- `tx_isk0..3` out 2: per-byte K-character flags; bit 0 qualifies [7:0].

## Operation
- Idle condition is `reset | ~ready`. While idle:
  - `tx_frame` = 0 and `sep_cnt` = 0.
  - Every lane outputs `tx_data` = 16'hFFBC and `tx_isk` = 2'b01. This is the reset value of every output.
- Otherwise `tx_frame` (2 bits) increments every cycle and wraps 3→0. `sep_cnt` (4 bits) increments every cycle and wraps 15→0.
- Lane word by `tx_frame`, where D is the lane's 56-bit slice:
  - 0: {D[7:0], sep}, isk 01
  - 1: D[23:8], isk 00
  - 2: D[39:24], isk 00
  - 3: D[55:40], isk 00
- `sep` is combinational from current inputs. Priority: `bc0` → 8'h1C; else `resync` → 8'h3C; else `overflow` → 8'hFC; else the BX-sequence code.
- BX-sequence code is selected by `sel`: 0→BC, 1→F7, 2→FB, 3→FD.
- All lanes share the same `sep`. Lanes 2 and 3 duplicate lanes 0 and 1.
- Inputs are sampled only in the cycle that loads the corresponding word. There is no holding of `gem_data` across a frame.

## Timing
- Outputs are registered with one-cycle latency: the word for `tx_frame` = k appears at the edge that ends the cycle in which `tx_frame` = k.
- First ready-high cycle after idle has `tx_frame` = 0, so the first output after idle is a frame-0 word carrying `sep`.
- Frame n (n = 0,1,…) starts with `sep_cnt` = 4n mod 16, so local `sel` = n mod 4.
- `ready` or `reset` asserting mid-frame aborts the frame on the next edge (idle word) and restarts at frame 0 when released.
- Simultaneous `bc0`, `resync` and `overflow` resolve by the fixed priority above.
- `bxn_lsbs` wrap 3→0 has no special handling.

## Configuration
- `FRAME_CTRL_TTC_EN` defined: `sel` = `bxn_lsbs`, so the sequence code follows the TTC BX counter.
- Undefined: `sel` = `sep_cnt[3:2]`, a local TTC-independent rotation advancing once per frame. `bxn_lsbs` is unused.
- `sep_cnt` exists in both builds.

## Structure
- Package `gem_trig_link_pkg` holds:
  - K-codes: K_BC=8'hBC, K_F7, K_FB, K_FD, K_BC0=8'h1C, K_RESYNC=8'h3C, K_OVF=8'hFC.
  - Idle word 16'hFFBC, idle isk 2'b01.
  - Lane count 4 and lane payload width 56.
- Sub-module `gem_trig_link_lane` (instantiated ×4): takes the 56-bit slice, `sep`, `tx_frame` and idle, and registers `tx_data`/`tx_isk`.
- Top holds the counters and the `sep` mux.

## Test plan
- Reset held, then `ready`=0 with reset low: all lanes 16'hFFBC / 2'b01 each cycle; counters stay 0.
- `ready` rises, `gem_data[55:0]`=56'h0123_4567_89AB_CD, no flags, `bxn_lsbs`=0: lane 0 emits CDBC/01, then 89AB/00, 4567/00, 0123/00; lane 2 matches lane 0.
- `bc0`, `resync` and `overflow` all high at frame-0 cycle: `sep` = 1C. With only `resync` and `overflow` high: 3C. With only `overflow` high: FC. Each appears in byte [7:0], isk 01.
- Without `FRAME_CTRL_TTC_EN`, five consecutive clean frames: separators BC, F7, FB, FD, BC. With the macro defined, `bxn_lsbs`=2 → FB regardless of frame count.
- `ready` drops at `tx_frame`=2 for one cycle: next word FFBC/01, then the frame restarts with a frame-0 word and a local sequence code BC.
- Lane split: `gem_data[111:56]` distinct pattern appears on lanes 1 and 3 only.
